// File: rtl/serial_display_receiver.sv
// Receiver for the 3-wire display serial bus (data/latch/clk).
// Oversamples the bus pins, shifts data MSB-first on serial-clock rising
// edges and transfers the assembled frame on latch rising edges. A latch
// that closes a frame of the wrong length raises an error pulse instead.
module serial_display_receiver #(
  parameter int unsigned FRAME_BITS  = 32,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                                i_clk,
  input  logic                                i_reset_n,
  input  logic                                i_en,
  input  logic                                i_serial_data,
  input  logic                                i_serial_latch,
  input  logic                                i_serial_clk,
  output logic [FRAME_BITS-1:0]               o_frame,
  output logic                                o_frame_valid,
  output logic                                o_frame_error,
  output logic [$clog2(FRAME_BITS+2)-1:0]     o_bit_count
);

  localparam int unsigned CW = $clog2(FRAME_BITS + 2);
  localparam logic [CW-1:0] CNT_FULL = CW'(FRAME_BITS);
  localparam logic [CW-1:0] CNT_SAT  = CW'(FRAME_BITS + 1);

  logic [SYNC_STAGES-1:0] sync_data;
  logic [SYNC_STAGES-1:0] sync_clk;
  logic [SYNC_STAGES-1:0] sync_latch;
  logic                   hist_clk;
  logic                   hist_latch;

  logic                   data_s;
  logic                   clk_rise;
  logic                   latch_rise;

  logic [FRAME_BITS-1:0]  shreg;
  logic [FRAME_BITS-1:0]  shreg_nx;
  logic [FRAME_BITS-1:0]  frame_nx;
  logic [CW-1:0]          count_nx;
  logic                   valid_nx;
  logic                   error_nx;

  // Pin synchronizers plus one history flop for edge detection; these keep
  // running while disabled so re-enabling never sees a stale edge.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      sync_data  <= '0;
      sync_clk   <= '0;
      sync_latch <= '0;
      hist_clk   <= 1'b0;
      hist_latch <= 1'b0;
    end else begin
      sync_data  <= {sync_data[SYNC_STAGES-2:0], i_serial_data};
      sync_clk   <= {sync_clk[SYNC_STAGES-2:0], i_serial_clk};
      sync_latch <= {sync_latch[SYNC_STAGES-2:0], i_serial_latch};
      hist_clk   <= sync_clk[SYNC_STAGES-1];
      hist_latch <= sync_latch[SYNC_STAGES-1];
    end
  end

  assign data_s     = sync_data[SYNC_STAGES-1];
  assign clk_rise   = sync_clk[SYNC_STAGES-1] & ~hist_clk;
  assign latch_rise = sync_latch[SYNC_STAGES-1] & ~hist_latch;

  // Next-state for shift/count/frame. A coincident shift is applied before
  // the latch is evaluated, so the latch sees the post-shift count and data.
  always_comb begin
    shreg_nx = shreg;
    frame_nx = o_frame;
    count_nx = o_bit_count;
    valid_nx = 1'b0;
    error_nx = 1'b0;
    if (!i_en) begin
      count_nx = '0;
    end else begin
      if (clk_rise) begin
        shreg_nx = {shreg[FRAME_BITS-2:0], data_s};
        if (o_bit_count != CNT_SAT) begin
          count_nx = o_bit_count + 1'b1;
        end
      end
      if (latch_rise) begin
        if (count_nx == CNT_FULL) begin
          frame_nx = shreg_nx;
          valid_nx = 1'b1;
        end else begin
          error_nx = 1'b1;
        end
        count_nx = '0;
      end
    end
  end

  // Receive datapath and output registers.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      shreg         <= '0;
      o_frame       <= '0;
      o_bit_count   <= '0;
      o_frame_valid <= 1'b0;
      o_frame_error <= 1'b0;
    end else begin
      shreg         <= shreg_nx;
      o_frame       <= frame_nx;
      o_bit_count   <= count_nx;
      o_frame_valid <= valid_nx;
      o_frame_error <= error_nx;
    end
  end

endmodule

// File: doc/serial_display_receiver.md
Name: serial_display_receiver

Overview:
Receiving end of the clock's 3-wire display serial bus (data/latch/clk), the interface the digital clock core drives toward its 7-segment shift registers. Oversamples the three bus pins with the system clock, shifts bits MSB-first on each serial-clock rising edge, and transfers the assembled frame to a parallel output register on each latch rising edge. It serves as a display-side decoder for FPGA bring-up and as a self-checking monitor in the clock's testbench. Frames with the wrong bit count are flagged and discarded.

Parameters:
FRAME_BITS, 32, bits per display frame (4 digits x 8 segments); must be >= 2.
SYNC_STAGES, 2, flip-flop synchronizer depth on each bus pin; must be >= 2.

Ports:
i_clk  input  1  system clock, 5 MHz nominal
i_reset_n  input  1  asynchronous active-low reset
i_en  input  1  receive enable
i_serial_data  input  1  bus data pin, asynchronous to i_clk
i_serial_latch  input  1  bus latch pin, asynchronous to i_clk
i_serial_clk  input  1  bus shift clock pin, asynchronous to i_clk
o_frame  output  FRAME_BITS  last accepted frame; first-shifted bit at MSB
o_frame_valid  output  1  one-cycle pulse when o_frame is updated
o_frame_error  output  1  one-cycle pulse when a latch arrives with bit count != FRAME_BITS
o_bit_count  output  $clog2(FRAME_BITS+2)  bits received since last latch, saturating

Behaviour:
- Reset (i_reset_n low, asynchronous): all synchronizer stages, edge-history regs, shift register, o_frame, o_bit_count = 0; o_frame_valid = o_frame_error = 0. Release is synchronous to i_clk by the surrounding reset logic; block takes no extra action.
- Sync: each pin passes through SYNC_STAGES flops; a history flop holds the previous synced value. clk_rise = synced_clk & ~hist_clk; latch_rise likewise. Data uses the synced data value in the same cycle as clk_rise (equal pipeline depth).
- Latency: a pin edge first sampled at i_clk edge k produces its action (shift/count/frame update, pulses) in the registers at edge k+SYNC_STAGES; pulses last exactly one cycle.
- Bus timing requirement (stimulus side): serial clk and latch high and low >= 2 i_clk cycles each; data stable >= 2 i_clk cycles around serial-clk rise. 1 MHz bus at 5 MHz system clock meets this.
- Shift on clk_rise (i_en=1): shreg <= {shreg[FRAME_BITS-2:0], data}; o_bit_count increments, saturating at FRAME_BITS+1 (overflow marker). Extra bits keep shifting; shreg holds the last FRAME_BITS bits.
- Latch on latch_rise (i_en=1): if count == FRAME_BITS, o_frame <= shreg, o_frame_valid=1; else o_frame unchanged, o_frame_error=1 (this includes count 0). In both cases o_bit_count <= 0. shreg is not cleared.
- Simultaneous clk_rise and latch_rise in the same cycle: the shift is applied first. The latch evaluates the post-shift count and post-shift shreg. o_bit_count ends at 0.
- i_en=0: synchronizers and history flops keep running, so no false edge appears on re-enable. Edges are ignored; o_bit_count forced to 0; o_frame held; no pulses. A partial frame spanning an i_en drop is therefore discarded.
- Reset mid-frame: partial frame and count are lost. The first latch after reset with fewer than FRAME_BITS new bits gives an error.
- Latch level high across many cycles triggers only once (edge-detected).

Test Plan:
- FRAME_BITS=32: shift 0xDEADBEEF MSB-first, then latch -> o_frame=0xDEADBEEF, o_frame_valid high exactly 1 cycle, 2 cycles after latch sampled, o_bit_count=0.
- Shift 31 bits of 0x12345678, then latch -> o_frame_error 1-cycle pulse, o_frame keeps previous 0xDEADBEEF, no valid pulse. Repeat with 33 bits -> error, o_bit_count had saturated at 33.
- Drive serial clk and latch rising in the same i_clk cycle on the 32nd bit of 0xA5A5A5A5 -> valid pulse, o_frame=0xA5A5A5A5.
- Shift 16 bits, assert i_reset_n low for 1 cycle -> all outputs 0. Then send 32 bits of 0x0F0F0F0F plus latch -> o_frame=0x0F0F0F0F, valid.
- Shift 10 bits, drop i_en for 20 cycles with toggling pins, re-enable, send 32 bits of 0xCAFEF00D plus latch -> valid, o_frame=0xCAFEF00D. A latch during i_en=0 -> no pulses.
- Hold latch high 50 cycles after a good frame -> exactly one valid pulse; a second latch with 0 new bits -> error pulse.
